// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the IF/ID front-end pipeline controller:
// FSM state encoding, the flush NOP word and the register index width.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_REDIR_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between a load in EX and the ID sources.
// Register 0 is hardwired to zero, so a load into it never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID front-end controller: boot hold-off, fetch-wait and load-use stalls,
// and branch/jump redirects that may have to wait for the instruction memory.
module ifid_pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             imem_ack,
  output logic             imem_req,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             CNTEN,
  output logic             PCsel,
  output logic [31:0]      JumporBranch,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= '0;
      pend_target_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_target_q <= pend_target_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pend_target_d = pend_target_q;
    imem_req      = 1'b0;
    CNTEN         = 1'b0;
    PCsel         = 1'b0;
    JumporBranch  = '0;
    IFID_flush    = 1'b0;
    IDEX_bubble   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        imem_req = 1'b1;
        // A redirect squashes the ID instruction, so it outranks any load-use stall.
        if (ex_redirect) begin
          PCsel        = 1'b1;
          JumporBranch = ex_target;
          IFID_flush   = 1'b1;
          IDEX_bubble  = 1'b1;
          CNTEN        = imem_ack;
          if (!imem_ack) begin
            pend_target_d = ex_target;
            state_d       = ST_REDIR_WAIT;
          end
        end else if (load_use || !imem_ack) begin
          IDEX_bubble = 1'b1;
        end else begin
          CNTEN = 1'b1;
        end
      end
      ST_REDIR_WAIT: begin
        // Keep presenting the captured target until the fetch completes.
        imem_req     = 1'b1;
        PCsel        = 1'b1;
        JumporBranch = pend_target_q;
        IFID_flush   = 1'b1;
        IDEX_bubble  = 1'b1;
        CNTEN        = imem_ack;
        if (imem_ack) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((state_q == ST_RUN || state_q == ST_REDIR_WAIT) && !CNTEN &&
        (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Bench for ifid_pipe_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the controller rules.
module tb_ifid_pipe_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RSTB;
  logic             imem_ack;
  logic             imem_req;
  logic             ex_redirect;
  logic [31:0]      ex_target;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             CNTEN;
  logic             PCsel;
  logic [31:0]      JumporBranch;
  logic             IFID_flush;
  logic             IDEX_bubble;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Model: cycles of boot hold-off left, whether a redirect is waiting on the
  // fetch (and its target), and the stall tally.
  int          m_boot_left;
  bit          m_waiting;
  logic [31:0] m_pend;
  int          m_stall;

  ifid_pipe_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK          (CLK),
    .RSTB         (RSTB),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .CNTEN        (CNTEN),
    .PCsel        (PCsel),
    .JumporBranch (JumporBranch),
    .IFID_flush   (IFID_flush),
    .IDEX_bubble  (IDEX_bubble),
    .stall_count  (stall_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks outputs at once,
  // then releases one clock later, again at posedge+1.
  task automatic apply_reset();
    RSTB = 1'b0;
    #1;
    chk("rst_cnten", CNTEN, 0);
    chk("rst_pcsel", PCsel, 0);
    chk("rst_jb", JumporBranch, 0);
    chk("rst_flush", IFID_flush, 0);
    chk("rst_bubble", IDEX_bubble, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_stall", stall_count, 0);
    m_boot_left = BOOT_CYCLES;
    m_waiting   = 1'b0;
    m_pend      = '0;
    m_stall     = 0;
    @(posedge CLK);
    #1;
    RSTB = 1'b1;
  endtask

  // One clock cycle: drive inputs at posedge+1, check combinational outputs
  // mid-cycle, then check the registered stall count after the edge.
  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic mr,
                       input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic ack);
    logic        e_cnten, e_pcsel, e_flush, e_bub, e_req;
    logic [31:0] e_jb;
    bit          hz;
    ex_redirect = redir;
    ex_target   = tgt;
    ex_memread  = mr;
    ex_rt       = ert;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = urt;
    imem_ack    = ack;
    #2;
    e_cnten = 0; e_pcsel = 0; e_flush = 0; e_bub = 0; e_req = 0; e_jb = '0;
    hz = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
    if (m_boot_left > 0) begin
      // boot hold-off: everything quiet
    end else if (m_waiting) begin
      e_req = 1; e_pcsel = 1; e_jb = m_pend; e_flush = 1; e_bub = 1; e_cnten = ack;
    end else begin
      e_req = 1;
      if (redir) begin
        e_pcsel = 1; e_jb = tgt; e_flush = 1; e_bub = 1; e_cnten = ack;
      end else if (hz || !ack) begin
        e_bub = 1;
      end else begin
        e_cnten = 1;
      end
    end
    chk("cnten", CNTEN, e_cnten);
    chk("pcsel", PCsel, e_pcsel);
    chk("jumporbranch", JumporBranch, e_jb);
    chk("ifid_flush", IFID_flush, e_flush);
    chk("idex_bubble", IDEX_bubble, e_bub);
    chk("imem_req", imem_req, e_req);
    @(posedge CLK);
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else begin
      if (!e_cnten && m_stall < STALL_MAX) m_stall++;
      if (m_waiting) begin
        if (ack) m_waiting = 0;
      end else if (redir && !ack) begin
        m_waiting = 1;
        m_pend    = tgt;
      end
    end
    #1;
    chk("stall_count", stall_count, 32'(m_stall));
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ack);
  endtask

  initial begin
    ex_redirect = 0; ex_target = '0; ex_memread = 0; ex_rt = '0;
    id_rs = '0; id_rt = '0; id_uses_rt = 0; imem_ack = 1;
    apply_reset();

    // Boot with ack high: CNTEN low for BOOT_CYCLES cycles, then high.
    repeat (BOOT_CYCLES + 2) idle(1'b1);

    // Load-use on rs, then the same pattern with register 0.
    cycle(1'b0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1);
    idle(1'b1);
    cycle(1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    // rt match only counts when the ID instruction reads rt.
    cycle(1'b0, 32'h0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1);

    // Redirect with immediate ack, then a quiet cycle.
    cycle(1'b1, 32'h0000_0040, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(1'b1);

    // Redirect waiting three cycles for the fetch; later targets are ignored.
    cycle(1'b1, 32'h0000_0080, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0099, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(1'b1);

    // Fetch wait without redirect.
    idle(1'b0);
    idle(1'b1);

    // Redirect coinciding with a load-use hazard.
    cycle(1'b1, 32'h0000_0100, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
    idle(1'b1);

    // Reset while a redirect is pending; the target must be forgotten.
    cycle(1'b1, 32'h0000_0200, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    apply_reset();
    repeat (BOOT_CYCLES + 3) idle(1'b1);

    // Random traffic; small register range makes hazards frequent and the
    // narrow stall counter reaches saturation.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom(), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
